// File: rtl/debug_cmd_decoder.sv
// debug_cmd_decoder
//   Assembles the debug UART byte stream into debugger commands. A command is
//   one command byte {op[2:0], marker[2:0], len[1:0]} followed by len+1
//   payload bytes, least significant byte first. A completed command is offered
//   on a valid/ready port and held stable until it is taken. A bad marker, an
//   oversized length or an inter-byte stall raises a one-cycle error strobe and
//   drops the partial command.
//   Optional feature macro: DEBUG_CMD_CHECKSUM_EN -- when defined, every command
//   carries one trailing byte equal to the XOR of the command byte and all
//   payload bytes. A mismatch is reported as error code 0.

module debug_cmd_decoder #(
  parameter int         DATA_W      = 32,
  parameter int         TIMEOUT_CYC = 5000,
  parameter logic [2:0] MARKER      = 3'b111
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [2:0]        cmd_op,
  output logic [DATA_W-1:0] cmd_data,
  output logic [1:0]        cmd_size,
  output logic              err_pulse,
  output logic [1:0]        err_code
);

  localparam int PAYLOAD_BYTES = DATA_W / 8;

  // The idle counter counts byte-less cycles in PAYLOAD/CHECK; the command is
  // dropped in the TIMEOUT_CYC-th such cycle unless a byte arrives in it.
  localparam int               TMO_LIM  = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
  localparam int               TMO_W    = $clog2(TMO_LIM + 2);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_LIM);

  localparam logic [1:0] ERR_MARKER  = 2'd1;
  localparam logic [1:0] ERR_LENGTH  = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;
`ifdef DEBUG_CMD_CHECKSUM_EN
  localparam logic [1:0] ERR_CHECKSUM = 2'd0;
`endif

`ifdef DEBUG_CMD_CHECKSUM_EN
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PAYLOAD = 2'd1,
    S_CHECK   = 2'd2,
    S_HOLD    = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PAYLOAD = 2'd1,
    S_HOLD    = 2'd3
  } state_t;
`endif

  state_t              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [1:0]          len_q, len_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                err_pulse_q, err_pulse_d;
  logic [1:0]          err_code_q, err_code_d;
`ifdef DEBUG_CMD_CHECKSUM_EN
  logic [7:0]          xor_q, xor_d;
`endif

  logic                byte_acc;
  logic                len_too_long;
  logic                last_byte;
  logic                tmo_expire;
  logic [TMO_W-1:0]    tmo_inc;

  assign rx_ready     = (state_q != S_HOLD);
  assign byte_acc     = rx_valid && rx_ready;
  // Payload byte count is len+1; compare in 3 bits so len=3 cannot wrap.
  assign len_too_long = ({1'b0, rx_data[1:0]} + 3'd1) > 3'(PAYLOAD_BYTES);
  assign last_byte    = (cnt_q == len_q);
  assign tmo_expire   = (TIMEOUT_CYC != 0) && (tmo_q == TMO_LAST);
  assign tmo_inc      = (TIMEOUT_CYC == 0) ? '0 : tmo_q + TMO_W'(1);

  assign cmd_valid = (state_q == S_HOLD);
  assign cmd_op    = op_q;
  assign cmd_data  = data_q;
  assign cmd_size  = len_q;
  assign err_pulse = err_pulse_q;
  assign err_code  = err_code_q;

  // Next-state and datapath update; an error always returns to IDLE and the
  // partially assembled command is simply never presented.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    len_d       = len_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    err_pulse_d = 1'b0;
    err_code_d  = err_code_q;
`ifdef DEBUG_CMD_CHECKSUM_EN
    xor_d       = xor_q;
`endif

    case (state_q)
      S_IDLE: begin
        tmo_d = '0;
        if (byte_acc) begin
          if (rx_data[4:2] != MARKER) begin
            err_pulse_d = 1'b1;
            err_code_d  = ERR_MARKER;
          end else if (len_too_long) begin
            err_pulse_d = 1'b1;
            err_code_d  = ERR_LENGTH;
          end else begin
            op_d    = rx_data[7:5];
            len_d   = rx_data[1:0];
            data_d  = '0;
            cnt_d   = '0;
            state_d = S_PAYLOAD;
`ifdef DEBUG_CMD_CHECKSUM_EN
            xor_d   = rx_data;
`endif
          end
        end
      end

      S_PAYLOAD: begin
        if (byte_acc) begin
          // An arriving byte beats a simultaneous timeout.
          tmo_d = '0;
          for (int k = 0; k < PAYLOAD_BYTES; k++) begin
            if (cnt_q == 2'(k)) begin
              data_d[8*k +: 8] = rx_data;
            end
          end
          cnt_d = cnt_q + 2'd1;
`ifdef DEBUG_CMD_CHECKSUM_EN
          xor_d = xor_q ^ rx_data;
          if (last_byte) begin
            state_d = S_CHECK;
          end
`else
          if (last_byte) begin
            state_d = S_HOLD;
          end
`endif
        end else if (tmo_expire) begin
          err_pulse_d = 1'b1;
          err_code_d  = ERR_TIMEOUT;
          tmo_d       = '0;
          state_d     = S_IDLE;
        end else begin
          tmo_d = tmo_inc;
        end
      end

`ifdef DEBUG_CMD_CHECKSUM_EN
      S_CHECK: begin
        if (byte_acc) begin
          tmo_d = '0;
          if (rx_data == xor_q) begin
            state_d = S_HOLD;
          end else begin
            err_pulse_d = 1'b1;
            err_code_d  = ERR_CHECKSUM;
            state_d     = S_IDLE;
          end
        end else if (tmo_expire) begin
          err_pulse_d = 1'b1;
          err_code_d  = ERR_TIMEOUT;
          tmo_d       = '0;
          state_d     = S_IDLE;
        end else begin
          tmo_d = tmo_inc;
        end
      end
`endif

      S_HOLD: begin
        tmo_d = '0;
        if (cmd_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset returns every output to its idle value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      len_q       <= '0;
      data_q      <= '0;
      cnt_q       <= '0;
      tmo_q       <= '0;
      err_pulse_q <= 1'b0;
      err_code_q  <= '0;
`ifdef DEBUG_CMD_CHECKSUM_EN
      xor_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      len_q       <= len_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      err_pulse_q <= err_pulse_d;
      err_code_q  <= err_code_d;
`ifdef DEBUG_CMD_CHECKSUM_EN
      xor_q       <= xor_d;
`endif
    end
  end

endmodule

// File: tb/tb_debug_cmd_decoder.sv
// tb_debug_cmd_decoder
//   Self-checking bench for debug_cmd_decoder. A 32-bit instance carries most
//   scenarios and is watched by a scoreboard monitor; a 16-bit instance covers
//   the length limit. Both use a short inter-byte timeout of 10 cycles.
//   Honours DEBUG_CMD_CHECKSUM_EN by appending the XOR byte to each command.

module tb_debug_cmd_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic [7:0]  rx_data;
  logic        rx_valid, rx_ready;
  logic        cmd_valid, cmd_ready;
  logic [2:0]  cmd_op;
  logic [31:0] cmd_data;
  logic [1:0]  cmd_size;
  logic        err_pulse;
  logic [1:0]  err_code;

  logic [7:0]  rx16_data;
  logic        rx16_valid, rx16_ready;
  logic        cmd16_valid, cmd16_ready;
  logic [2:0]  cmd16_op;
  logic [15:0] cmd16_data;
  logic [1:0]  cmd16_size;
  logic        err16_pulse;
  logic [1:0]  err16_code;

  debug_cmd_decoder #(.DATA_W(32), .TIMEOUT_CYC(10), .MARKER(3'b111)) dut (
    .clk(clk), .reset(reset),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_size(cmd_size),
    .err_pulse(err_pulse), .err_code(err_code)
  );

  debug_cmd_decoder #(.DATA_W(16), .TIMEOUT_CYC(10), .MARKER(3'b111)) dut16 (
    .clk(clk), .reset(reset),
    .rx_data(rx16_data), .rx_valid(rx16_valid), .rx_ready(rx16_ready),
    .cmd_valid(cmd16_valid), .cmd_ready(cmd16_ready),
    .cmd_op(cmd16_op), .cmd_data(cmd16_data), .cmd_size(cmd16_size),
    .err_pulse(err16_pulse), .err_code(err16_code)
  );

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  size;
    logic [31:0] data;
  } exp_cmd_t;

  exp_cmd_t   exp_cmd_q[$];
  logic [1:0] exp_err_q[$];

  // Scoreboard monitor for the 32-bit instance: pops on each handshake and
  // each error strobe, and flags strobes longer than one cycle.
  bit prev_err = 1'b0;
  always @(negedge clk) begin
    exp_cmd_t   e;
    logic [1:0] ec;
    if (reset) begin
      prev_err = 1'b0;
    end else begin
      if (cmd_valid && cmd_ready) begin
        vectors++;
        if (exp_cmd_q.size() == 0) begin
          miscompares++;
          $display("FAIL sb_unexpected_cmd: op=%0d size=%0d data=%h, required no command", cmd_op, cmd_size, cmd_data);
        end else begin
          e = exp_cmd_q.pop_front();
          if ({cmd_op, cmd_size, cmd_data} !== {e.op, e.size, e.data}) begin
            miscompares++;
            $display("FAIL sb_cmd: op=%0d size=%0d data=%h, required op=%0d size=%0d data=%h",
                     cmd_op, cmd_size, cmd_data, e.op, e.size, e.data);
          end
        end
      end
      if (err_pulse) begin
        vectors++;
        if (prev_err) begin
          miscompares++;
          $display("FAIL sb_err_width: err_pulse high on consecutive cycles, required one cycle");
        end else if (exp_err_q.size() == 0) begin
          miscompares++;
          $display("FAIL sb_unexpected_err: err_code=%0d, required no error", err_code);
        end else begin
          ec = exp_err_q.pop_front();
          if (err_code !== ec) begin
            miscompares++;
            $display("FAIL sb_err_code: err_code=%0d, required %0d", err_code, ec);
          end
        end
      end
      prev_err = err_pulse;
    end
  end

  function automatic void push_cmd(input logic [2:0] op, input logic [1:0] size, input logic [31:0] data);
    exp_cmd_t e;
    e.op = op; e.size = size; e.data = data;
    exp_cmd_q.push_back(e);
  endfunction

  // All tasks start and end 1 time unit after a rising edge.
  task automatic send_byte(input bit use16, input logic [7:0] b);
    int n;
    n = 0;
    if (use16) begin rx16_data = b; rx16_valid = 1'b1; end
    else begin rx_data = b; rx_valid = 1'b1; end
    @(negedge clk);
    while (((use16 ? rx16_ready : rx_ready) !== 1'b1) && n < 40) begin
      n++;
      @(negedge clk);
    end
    if ((use16 ? rx16_ready : rx_ready) !== 1'b1) begin
      vectors++; miscompares++;
      $display("FAIL rx_ready_wait: rx_ready=%b after %0d cycles, required 1", use16 ? rx16_ready : rx_ready, n);
    end
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx16_valid = 1'b0;
  endtask

  task automatic send_cmd(input bit use16, input logic [7:0] cb, input logic [31:0] pl, input int nbytes);
`ifdef DEBUG_CMD_CHECKSUM_EN
    logic [7:0] ck;
    ck = cb;
`endif
    send_byte(use16, cb);
    for (int k = 0; k < nbytes; k++) begin
      send_byte(use16, pl[8*k +: 8]);
`ifdef DEBUG_CMD_CHECKSUM_EN
      ck = ck ^ pl[8*k +: 8];
`endif
    end
`ifdef DEBUG_CMD_CHECKSUM_EN
    send_byte(use16, ck);
`endif
  endtask

  task automatic handshake();
    cmd_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (cmd_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL hs_valid: cmd_valid=%b, required 1", cmd_valid);
    end
    @(posedge clk); #1;
    cmd_ready = 1'b0;
    @(negedge clk);
    vectors++;
    if ({cmd_valid, rx_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL hs_release: cmd_valid=%b rx_ready=%b, required 0 1", cmd_valid, rx_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rx_data = 8'h00; rx_valid = 1'b0; cmd_ready = 1'b0;
    rx16_data = 8'h00; rx16_valid = 1'b0; cmd16_ready = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({rx_ready, cmd_valid, cmd_op, cmd_data, cmd_size, err_pulse, err_code} !== {1'b1, 1'b0, 3'd0, 32'd0, 2'd0, 1'b0, 2'd0}) begin
      miscompares++;
      $display("FAIL reset_state: rdy=%b vld=%b op=%0d data=%h size=%0d ep=%b ec=%0d, required 1 0 0 0 0 0 0",
               rx_ready, cmd_valid, cmd_op, cmd_data, cmd_size, err_pulse, err_code);
    end
    vectors++;
    if ({rx16_ready, cmd16_valid, cmd16_data, err16_pulse, err16_code} !== {1'b1, 1'b0, 16'd0, 1'b0, 2'd0}) begin
      miscompares++;
      $display("FAIL reset_state16: rdy=%b vld=%b data=%h ep=%b ec=%0d, required 1 0 0 0 0",
               rx16_ready, cmd16_valid, cmd16_data, err16_pulse, err16_code);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_hold_stable();
    push_cmd(3'd1, 2'd3, 32'h12345678);
    send_cmd(1'b0, 8'h3F, 32'h12345678, 4);
    // A byte offered while the command is held must be ignored.
    rx_data = 8'h3C; rx_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if ({cmd_valid, rx_ready, cmd_op, cmd_size, cmd_data} !== {1'b1, 1'b0, 3'd1, 2'd3, 32'h12345678}) begin
        miscompares++;
        $display("FAIL hold_stable[%0d]: vld=%b rdy=%b op=%0d size=%0d data=%h, required 1 0 1 3 12345678",
                 i, cmd_valid, rx_ready, cmd_op, cmd_size, cmd_data);
      end
    end
    @(posedge clk); #1;
    rx_valid = 1'b0;
    handshake();
  endtask

  task automatic test_single_byte();
    push_cmd(3'd1, 2'd0, 32'h000000AB);
    send_cmd(1'b0, 8'h3C, 32'h000000AB, 1);
    handshake();
  endtask

  task automatic test_bad_marker();
    exp_err_q.push_back(2'd1);
    send_byte(1'b0, 8'h38);
    @(negedge clk);
    vectors++;
    if ({err_pulse, err_code, cmd_valid, rx_ready} !== {1'b1, 2'd1, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL bad_marker: ep=%b ec=%0d vld=%b rdy=%b, required 1 1 0 1", err_pulse, err_code, cmd_valid, rx_ready);
    end
    @(posedge clk); #1;
    @(negedge clk);
    vectors++;
    if ({err_pulse, err_code, cmd_valid} !== {1'b0, 2'd1, 1'b0}) begin
      miscompares++;
      $display("FAIL bad_marker_after: ep=%b ec=%0d vld=%b, required 0 1 0", err_pulse, err_code, cmd_valid);
    end
    @(posedge clk); #1;
    push_cmd(3'd1, 2'd0, 32'h00000022);
    send_cmd(1'b0, 8'h3C, 32'h00000022, 1);
    handshake();
  endtask

  task automatic test_bad_length();
    send_byte(1'b1, 8'h3F);
    @(negedge clk);
    vectors++;
    if ({err16_pulse, err16_code, cmd16_valid, rx16_ready} !== {1'b1, 2'd2, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL bad_length: ep=%b ec=%0d vld=%b rdy=%b, required 1 2 0 1", err16_pulse, err16_code, cmd16_valid, rx16_ready);
    end
    @(posedge clk); #1;
    send_cmd(1'b1, 8'h3D, 32'h00000201, 2);
    @(negedge clk);
    vectors++;
    if ({cmd16_valid, cmd16_op, cmd16_size, cmd16_data, err16_pulse} !== {1'b1, 3'd1, 2'd1, 16'h0201, 1'b0}) begin
      miscompares++;
      $display("FAIL len16_cmd: vld=%b op=%0d size=%0d data=%h ep=%b, required 1 1 1 0201 0",
               cmd16_valid, cmd16_op, cmd16_size, cmd16_data, err16_pulse);
    end
    @(posedge clk); #1;
    cmd16_ready = 1'b1;
    @(posedge clk); #1;
    cmd16_ready = 1'b0;
    @(negedge clk);
    vectors++;
    if ({cmd16_valid, rx16_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL len16_release: vld=%b rdy=%b, required 0 1", cmd16_valid, rx16_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_timeout();
    int  k;
    bit  seen;
    exp_err_q.push_back(2'd3);
    send_byte(1'b0, 8'h3F);
    send_byte(1'b0, 8'h11);
    k = 0; seen = 1'b0;
    while (!seen && k < 30) begin
      @(negedge clk);
      k++;
      if (err_pulse === 1'b1) seen = 1'b1;
    end
    vectors++;
    if (!seen || k < 10 || k > 11 || err_code !== 2'd3 || cmd_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout: seen=%b after %0d cycles ec=%0d vld=%b, required 1 after 10..11 cycles ec=3 vld=0",
               seen, k, err_code, cmd_valid);
    end
    @(posedge clk); #1;
    // A byte arriving in the 10th idle cycle beats the timeout.
    push_cmd(3'd1, 2'd1, 32'h00000201);
    send_byte(1'b0, 8'h3D);
    send_byte(1'b0, 8'h01);
    repeat (9) @(posedge clk);
    #1;
    send_byte(1'b0, 8'h02);
`ifdef DEBUG_CMD_CHECKSUM_EN
    send_byte(1'b0, 8'h3E);
`endif
    handshake();
    push_cmd(3'd1, 2'd0, 32'h00000005);
    send_cmd(1'b0, 8'h3C, 32'h00000005, 1);
    handshake();
  endtask

  task automatic test_back_to_back();
    logic [2:0]  op;
    logic [1:0]  len;
    logic [31:0] pl, mask;
    cmd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      op  = 3'($urandom_range(0, 7));
      len = 2'($urandom_range(0, 3));
      pl  = $urandom();
      mask = (len == 2'd3) ? 32'hFFFF_FFFF : ((32'd1 << (8 * (int'(len) + 1))) - 32'd1);
      if (i == 3) begin
        exp_err_q.push_back(2'd1);
        send_byte(1'b0, {op, 3'b010, len});
      end
      push_cmd(op, len, pl & mask);
      send_cmd(1'b0, {op, 3'b111, len}, pl, int'(len) + 1);
    end
    repeat (3) @(posedge clk);
    #1;
    cmd_ready = 1'b0;
    vectors++;
    if (exp_cmd_q.size() != 0) begin
      miscompares++;
      $display("FAIL b2b_drain: %0d commands outstanding, required 0", exp_cmd_q.size());
    end
  endtask

  task automatic test_reset_mid();
    send_byte(1'b0, 8'h3F);
    send_byte(1'b0, 8'h11);
    reset = 1'b1;
    #1;
    vectors++;
    if ({rx_ready, cmd_valid, cmd_op, cmd_data, cmd_size, err_pulse, err_code} !== {1'b1, 1'b0, 3'd0, 32'd0, 2'd0, 1'b0, 2'd0}) begin
      miscompares++;
      $display("FAIL reset_mid: rdy=%b vld=%b op=%0d data=%h size=%0d ep=%b ec=%0d, required 1 0 0 0 0 0 0",
               rx_ready, cmd_valid, cmd_op, cmd_data, cmd_size, err_pulse, err_code);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    push_cmd(3'd1, 2'd0, 32'h00000005);
    send_cmd(1'b0, 8'h3C, 32'h00000005, 1);
    handshake();
  endtask

`ifdef DEBUG_CMD_CHECKSUM_EN
  task automatic test_checksum();
    push_cmd(3'd1, 2'd0, 32'h00000005);
    send_byte(1'b0, 8'h3C);
    send_byte(1'b0, 8'h05);
    send_byte(1'b0, 8'h39);
    handshake();
    exp_err_q.push_back(2'd0);
    send_byte(1'b0, 8'h3C);
    send_byte(1'b0, 8'h05);
    send_byte(1'b0, 8'h00);
    @(negedge clk);
    vectors++;
    if ({err_pulse, err_code, cmd_valid, rx_ready} !== {1'b1, 2'd0, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL checksum_bad: ep=%b ec=%0d vld=%b rdy=%b, required 1 0 0 1", err_pulse, err_code, cmd_valid, rx_ready);
    end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    test_reset();
    test_hold_stable();
    test_single_byte();
    test_bad_marker();
    test_bad_length();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
`ifdef DEBUG_CMD_CHECKSUM_EN
    test_checksum();
`endif
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (exp_cmd_q.size() != 0 || exp_err_q.size() != 0) begin
      miscompares++;
      $display("FAIL sb_drain: %0d commands and %0d errors outstanding, required 0 and 0", exp_cmd_q.size(), exp_err_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
